fst_core: RTL and testbench

Single-cycle 16-bit processor core with eight general registers and a flags register. It fetches from an external instruction memory (imem) via `pc`/`inst`, and loads/stores through an external data memory (dmem) with separate read and write address buses. It drives a simple word-wide I/O port and raises `is_halt` when it stops. It sits between imem, dmem and the top-level I/O; imem and dmem are separate blocks with combinational read and synchronous write.

---
 rtl/fst_core.sv | 189 ++++++++++++++++++
 tb/tb_fst_core.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fst_core.sv
// fst_core: single-cycle 16-bit core with r0-r7, S/Z/C/V flags and a halt latch.
// imem and dmem are external with combinational read; all state commits on clk.
module fst_core (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pc,
    input  logic [15:0] inst,
    output logic [15:0] main_mem_read_adr,
    input  logic [15:0] main_mem_dat,
    output logic        main_mem_write,
    output logic [15:0] main_mem_write_adr,
    output logic [15:0] main_mem_write_dat,
    input  logic [15:0] in_dat,
    output logic        out_en,
    output logic [15:0] out_dat,
    output logic        is_halt
);
    logic [15:0] pc_q, pc_d;
    logic [15:0] regs_q [8];
    logic        s_q, z_q, c_q, v_q;
    logic        s_d, z_d, c_d, v_d;
    logic        halt_q, halt_d;

    logic        rf_we;
    logic [2:0]  rf_wa;
    logic [15:0] rf_wd;
    logic        mem_we, out_req, br_take, set_flags;
    logic [15:0] alu_res;
    logic        alu_c, alu_v;

    logic [1:0]  cls;
    logic [2:0]  ra, rb;
    logic [3:0]  op, d4;
    logic [15:0] sx8, rs_v, rd_v, ea, pc_inc, pc_br;
    logic [16:0] add17, sub17, sr17, sra17;
    logic [31:0] sl32;

    assign cls    = inst[15:14];
    assign ra     = inst[13:11];
    assign rb     = inst[10:8];
    assign op     = inst[7:4];
    assign d4     = inst[3:0];
    assign sx8    = {{8{inst[7]}}, inst[7:0]};
    assign rs_v   = regs_q[ra];
    assign rd_v   = regs_q[rb];
    assign ea     = rd_v + sx8;
    assign pc_inc = pc_q + 16'd1;
    assign pc_br  = pc_inc + sx8;

    // Bit 16 of the 17-bit sum/difference is carry-out / borrow.
    assign add17 = {1'b0, rd_v} + {1'b0, rs_v};
    assign sub17 = {1'b0, rd_v} - {1'b0, rs_v};
    // Shifters keep one guard bit so the last bit shifted out falls out as C.
    assign sl32  = {16'h0, rd_v} << d4;
    assign sr17  = {rd_v, 1'b0} >> d4;
    assign sra17 = $signed({rd_v, 1'b0}) >>> d4;

    // Decode/execute: next pc, register write, flags, memory/port strobes.
    always_comb begin
        pc_d      = pc_inc;
        halt_d    = halt_q;
        s_d       = s_q;
        z_d       = z_q;
        c_d       = c_q;
        v_d       = v_q;
        rf_we     = 1'b0;
        rf_wa     = rb;
        rf_wd     = 16'h0;
        mem_we    = 1'b0;
        out_req   = 1'b0;
        br_take   = 1'b0;
        set_flags = 1'b0;
        alu_res   = rd_v;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        if (halt_q) begin
            pc_d = pc_q;
        end else begin
            case (cls)
                2'b00: begin
                    rf_we = 1'b1;
                    rf_wa = ra;
                    rf_wd = main_mem_dat;
                end
                2'b01: mem_we = 1'b1;
                2'b10: begin
                    case (ra)
                        3'b000: begin
                            rf_we = 1'b1;
                            rf_wd = sx8;
                        end
                        3'b100: pc_d = pc_br;
                        3'b111: begin
                            case (rb)
                                3'b000:  br_take = z_q;
                                3'b001:  br_take = s_q ^ v_q;
                                3'b010:  br_take = z_q | (s_q ^ v_q);
                                3'b011:  br_take = ~z_q;
                                default: br_take = 1'b0;
                            endcase
                            if (br_take) pc_d = pc_br;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    case (op)
                        4'd0: begin
                            alu_res   = add17[15:0];
                            alu_c     = add17[16];
                            alu_v     = (rd_v[15] == rs_v[15]) && (add17[15] != rd_v[15]);
                            set_flags = 1'b1;
                            rf_we     = 1'b1;
                        end
                        4'd1, 4'd5: begin
                            alu_res   = sub17[15:0];
                            alu_c     = sub17[16];
                            alu_v     = (rd_v[15] != rs_v[15]) && (sub17[15] != rd_v[15]);
                            set_flags = 1'b1;
                            rf_we     = (op == 4'd1);
                        end
                        4'd2: begin alu_res = rd_v & rs_v; set_flags = 1'b1; rf_we = 1'b1; end
                        4'd3: begin alu_res = rd_v | rs_v; set_flags = 1'b1; rf_we = 1'b1; end
                        4'd4: begin alu_res = rd_v ^ rs_v; set_flags = 1'b1; rf_we = 1'b1; end
                        4'd6: begin alu_res = rs_v; rf_we = 1'b1; end
                        4'd8: begin
                            alu_res = sl32[15:0]; alu_c = sl32[16];
                            set_flags = 1'b1; rf_we = 1'b1;
                        end
                        4'd9: begin
                            alu_res = sl32[15:0] | sl32[31:16]; alu_c = sl32[16];
                            set_flags = 1'b1; rf_we = 1'b1;
                        end
                        4'd10: begin
                            alu_res = sr17[16:1]; alu_c = sr17[0];
                            set_flags = 1'b1; rf_we = 1'b1;
                        end
                        4'd11: begin
                            alu_res = sra17[16:1]; alu_c = sra17[0];
                            set_flags = 1'b1; rf_we = 1'b1;
                        end
                        4'd12: begin alu_res = in_dat; rf_we = 1'b1; end
                        4'd13: out_req = 1'b1;
                        4'd15: begin halt_d = 1'b1; pc_d = pc_q; end
                        default: ;
                    endcase
                    rf_wd = alu_res;
                    if (set_flags) begin
                        s_d = alu_res[15];
                        z_d = (alu_res == 16'h0);
                        c_d = alu_c;
                        v_d = alu_v;
                    end
                end
            endcase
        end
    end

    assign pc                 = pc_q;
    assign is_halt            = halt_q;
    assign main_mem_read_adr  = ea;
    assign main_mem_write_adr = ea;
    assign main_mem_write_dat = rs_v;
    // Reset masks the strobes so an instruction in flight has no side effect.
    assign main_mem_write     = reset & mem_we;
    assign out_en             = reset & out_req;
    assign out_dat            = out_en ? rs_v : 16'h0;

    // Architectural state register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q   <= 16'h0;
            halt_q <= 1'b0;
            s_q    <= 1'b0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0;
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_d;
            s_q    <= s_d;
            z_q    <= z_d;
            c_q    <= c_d;
            v_q    <= v_d;
            if (rf_we) regs_q[rf_wa] <= rf_wd;
        end
    end
endmodule

// File: tb/tb_fst_core.sv
// tb_fst_core: lockstep instruction-level reference model vs fst_core,
// directed programs followed by random programs.
module tb_fst_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc, inst, main_mem_read_adr, main_mem_dat;
    logic        main_mem_write;
    logic [15:0] main_mem_write_adr, main_mem_write_dat;
    logic [15:0] in_dat = 16'h0;
    logic        out_en;
    logic [15:0] out_dat;
    logic        is_halt;

    fst_core dut (
        .clk(clk), .reset(reset), .pc(pc), .inst(inst),
        .main_mem_read_adr(main_mem_read_adr), .main_mem_dat(main_mem_dat),
        .main_mem_write(main_mem_write), .main_mem_write_adr(main_mem_write_adr),
        .main_mem_write_dat(main_mem_write_dat), .in_dat(in_dat),
        .out_en(out_en), .out_dat(out_dat), .is_halt(is_halt)
    );

    always #5 clk = ~clk;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    assign inst         = imem[pc[7:0]];
    assign main_mem_dat = dmem[main_mem_read_adr[7:0]];
    always @(posedge clk) if (main_mem_write) dmem[main_mem_write_adr[7:0]] <= main_mem_write_dat;

    // reference model state
    logic [15:0] m_r [8];
    logic [15:0] m_pc;
    logic [15:0] m_mem [256];
    bit          m_s, m_z, m_c, m_v, m_halt;
    logic [15:0] last_out;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [15:0] NOP = 16'hC070;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sx16(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    function automatic logic [15:0] e_alu(input int op, input int rs, input int rd, input int n);
        return {2'b11, 3'(rs), 3'(rd), 4'(op), 4'(n)};
    endfunction
    function automatic logic [15:0] e_ld(input int ra, input int rb, input int d8);
        return {2'b00, 3'(ra), 3'(rb), 8'(d8)};
    endfunction
    function automatic logic [15:0] e_st(input int ra, input int rb, input int d8);
        return {2'b01, 3'(ra), 3'(rb), 8'(d8)};
    endfunction
    function automatic logic [15:0] e_li(input int rb, input int d8);
        return {2'b10, 3'b000, 3'(rb), 8'(d8)};
    endfunction
    function automatic logic [15:0] e_bc(input int cond, input int d8);
        return {2'b10, 3'b111, 3'(cond), 8'(d8)};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) imem[i] = NOP;
    endtask

    task automatic load_dmem(input bit rnd);
        for (int i = 0; i < 256; i++) begin
            dmem[i]  = rnd ? 16'($urandom) : 16'h0;
            m_mem[i] = dmem[i];
        end
    endtask

    // Hold reset for n edges, checking the forced outputs, then release.
    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        chk("rst_mem_write", main_mem_write, 0);
        chk("rst_out_en", out_en, 0);
        chk("rst_out_dat", out_dat, 0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
        m_pc = 16'h0; m_s = 0; m_z = 0; m_c = 0; m_v = 0; m_halt = 0;
        chk("rst_pc", pc, 16'h0);
        chk("rst_halt", is_halt, 0);
        reset = 1'b1;
    endtask

    // One instruction: model predicts outputs and next state, DUT is compared.
    task automatic cycle(input bit rnd_in);
        logic [15:0] ins, a, b, res, adr, npc;
        int          ra, rb, op, n, d8, full, sv;
        bit          c, v, wr, setf, we, oe, ld, tk, hlt;
        if (rnd_in) in_dat = 16'($urandom);
        #1;
        ins = imem[m_pc[7:0]];
        ra = int'(ins[13:11]); rb = int'(ins[10:8]); op = int'(ins[7:4]); n = int'(ins[3:0]);
        d8 = int'($signed(ins[7:0]));
        a = m_r[rb]; b = m_r[ra];
        adr = 16'(int'(a) + d8);
        npc = 16'(int'(m_pc) + 1);
        res = a; c = 0; v = 0; wr = 0; setf = 0; we = 0; oe = 0; ld = 0; hlt = 0;
        if (m_halt) npc = m_pc;
        else if (ins[15:14] == 2'b00) ld = 1;
        else if (ins[15:14] == 2'b01) we = 1;
        else if (ins[15:14] == 2'b10) begin
            if (ra == 0) begin wr = 1; res = 16'(d8); end
            else if (ra == 4) npc = 16'(int'(m_pc) + 1 + d8);
            else if (ra == 7) begin
                case (rb)
                    0: tk = m_z;
                    1: tk = m_s ^ m_v;
                    2: tk = m_z | (m_s ^ m_v);
                    3: tk = !m_z;
                    default: tk = 0;
                endcase
                if (tk) npc = 16'(int'(m_pc) + 1 + d8);
            end
        end else begin
            case (op)
                0: begin
                    full = int'(a) + int'(b); res = full[15:0]; c = full > 65535;
                    sv = sx16(a) + sx16(b); v = sv > 32767 || sv < -32768;
                    wr = 1; setf = 1;
                end
                1, 5: begin
                    full = int'(a) - int'(b); res = full[15:0]; c = a < b;
                    sv = sx16(a) - sx16(b); v = sv > 32767 || sv < -32768;
                    wr = (op == 1); setf = 1;
                end
                2: begin res = a & b; wr = 1; setf = 1; end
                3: begin res = a | b; wr = 1; setf = 1; end
                4: begin res = a ^ b; wr = 1; setf = 1; end
                6: begin res = b; wr = 1; end
                8, 9, 10, 11: begin
                    for (int k = 0; k < n; k++) begin
                        if (op == 8)       begin c = res[15]; res = res << 1; end
                        else if (op == 9)  begin c = res[15]; res = {res[14:0], c}; end
                        else if (op == 10) begin c = res[0];  res = res >> 1; end
                        else               begin c = res[0];  res = {res[15], res[15:1]}; end
                    end
                    wr = 1; setf = 1;
                end
                12: begin res = in_dat; wr = 1; end
                13: oe = 1;
                15: begin hlt = 1; npc = m_pc; end
                default: ;
            endcase
        end
        chk("pc", pc, m_pc);
        chk("is_halt", is_halt, m_halt);
        chk("out_en", out_en, oe);
        if (oe) begin
            chk("out_dat", out_dat, b);
            last_out = out_dat;
        end
        chk("mem_write", main_mem_write, we);
        if (we) begin
            chk("mem_wadr", main_mem_write_adr, adr);
            chk("mem_wdat", main_mem_write_dat, b);
            m_mem[adr[7:0]] = b;
        end
        if (ld) begin
            chk("mem_radr", main_mem_read_adr, adr);
            m_r[ra] = m_mem[adr[7:0]];
        end
        if (wr) m_r[rb] = res;
        if (setf) begin m_s = res[15]; m_z = (res == 16'h0); m_c = c; m_v = v; end
        if (hlt) m_halt = 1;
        m_pc = npc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_state(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", tag, i), dut.regs_q[i], m_r[i]);
        chk({tag, "_S"}, dut.s_q, m_s);
        chk({tag, "_Z"}, dut.z_q, m_z);
        chk({tag, "_C"}, dut.c_q, m_c);
        chk({tag, "_V"}, dut.v_q, m_v);
        for (int i = 0; i < 256; i++) if (dmem[i] !== m_mem[i]) diff++;
        chk({tag, "_dmem_diffs"}, diff, 0);
    endtask

    initial begin
        logic [15:0] w;
        last_out = 16'h0;
        load_dmem(0);

        // add, flags and output port
        clear_prog();
        imem[0] = e_li(1, 5); imem[1] = e_li(2, -3);
        imem[2] = e_alu(0, 1, 2, 0); imem[3] = e_alu(13, 2, 0, 0);
        do_reset(3);
        repeat (4) cycle(0);
        chk("add_out", last_out, 16'h0002);
        chk("add_C", dut.c_q, 1); chk("add_V", dut.v_q, 0);
        chk("add_Z", dut.z_q, 0); chk("add_S", dut.s_q, 0);
        chk_state("add");

        // store then load-use without stall
        clear_prog();
        imem[0] = e_li(3, 8'h7F); imem[1] = e_st(3, 0, 4);
        imem[2] = e_ld(4, 0, 4);  imem[3] = e_alu(13, 4, 0, 0);
        do_reset(2);
        repeat (4) cycle(0);
        chk("ldst_out", last_out, 16'h007F);
        chk("ldst_dmem4", dmem[4], 16'h007F);
        chk_state("ldst");

        // countdown loop: two taken BNE, then fall through
        clear_prog();
        imem[0] = e_li(1, 3); imem[1] = e_li(2, 1);
        imem[2] = e_alu(1, 2, 1, 0); imem[3] = e_bc(3, -2);
        do_reset(1);
        repeat (8) cycle(0);
        chk("loop_pc", pc, 16'd4);
        chk("loop_r1", dut.regs_q[1], 16'h0);
        chk_state("loop");

        // input port and arithmetic shift right
        clear_prog();
        imem[0] = e_alu(12, 0, 5, 0); imem[1] = e_alu(11, 0, 5, 4); imem[2] = e_alu(13, 5, 0, 0);
        do_reset(1);
        in_dat = 16'hA5A5;
        repeat (3) cycle(0);
        chk("sra_out", last_out, 16'hFA5A);
        chk("sra_C", dut.c_q, 0);
        chk_state("sra");

        // halt at 6 freezes everything until reset
        clear_prog();
        imem[6] = e_alu(15, 0, 0, 0); imem[7] = e_alu(13, 0, 0, 0); imem[8] = e_st(0, 0, 0);
        do_reset(1);
        repeat (7) cycle(0);
        chk("hlt_is_halt", is_halt, 1);
        chk("hlt_pc", pc, 16'd6);
        repeat (4) cycle(0);
        chk("hlt_pc_frozen", pc, 16'd6);
        do_reset(1);
        chk("hlt_cleared", is_halt, 0);

        // reset landing on a store suppresses the write
        clear_prog();
        imem[0] = e_li(1, 9); imem[1] = e_st(1, 0, 8);
        do_reset(1);
        cycle(0);
        do_reset(1);
        chk_state("midrst");

        // random programs against the model
        for (int p = 0; p < 40; p++) begin
            load_dmem(1);
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                if (w[15:14] == 2'b11 && w[7:4] == 4'd15 && $urandom_range(3) != 0) w[7:4] = 4'd0;
                imem[i] = w;
            end
            do_reset(1);
            repeat (60) cycle(1);
            chk_state($sformatf("rnd%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
